sap_1_controller_sequencer: RTL

Controller-sequencer for the SAP-1 datapath; drives the control word for the PC, MAR, RAM, IR, accumulator, adder/subtractor, B register and output register.
- A one-hot T-state ring counter steps each instruction through fetch (T1-T3) and execute (T4-T6).
- Execute-phase control signals are decoded from the IR opcode nibble.
- It sequences the adder/subtractor through SU and EU and halts the machine on HLT.

---
 rtl/sap_1_pkg.sv | 34 +++
 rtl/sap_1_controller_sequencer_if.sv | 19 +
 rtl/sap_1_ring_counter.sv | 33 +++
 rtl/sap_1_controller_sequencer.sv | 119 +++++++++++
 4 files changed

// File: rtl/sap_1_pkg.sv
// Shared constants for the SAP-1 controller-sequencer: opcodes, one-hot T-states and
// control-word bit positions (CP is the MSB, LO the LSB).
package sap_1_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OPC_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OPC_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OPC_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OPC_W-1:0] OP_HLT = 4'b1111;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam int unsigned CwW  = 12;
  localparam int unsigned CwCp = 11;
  localparam int unsigned CwEp = 10;
  localparam int unsigned CwLm = 9;
  localparam int unsigned CwCe = 8;
  localparam int unsigned CwLi = 7;
  localparam int unsigned CwEi = 6;
  localparam int unsigned CwLa = 5;
  localparam int unsigned CwEa = 4;
  localparam int unsigned CwSu = 3;
  localparam int unsigned CwEu = 2;
  localparam int unsigned CwLb = 1;
  localparam int unsigned CwLo = 0;

endpackage

// File: rtl/sap_1_controller_sequencer_if.sv
// Control bundle between the SAP-1 sequencer (master) and the datapath (slave).
interface sap_1_controller_sequencer_if;
  import sap_1_pkg::*;

  logic [OPC_W-1:0] opcode;
  logic [5:0]       t_state;
  logic CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO, HLT;

  modport master (
    input  opcode,
    output t_state, CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO, HLT
  );

  modport slave (
    output opcode,
    input  t_state, CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO, HLT
  );

endinterface

// File: rtl/sap_1_ring_counter.sv
// One-hot T-state ring: Clr and restart force T1, hold freezes, otherwise rotates left.
module sap_1_ring_counter
  import sap_1_pkg::*;
(
  input  logic       Clk,
  input  logic       Clr,
  input  logic       hold_i,
  input  logic       restart_i,
  output logic [5:0] state_o
);

  logic [5:0] state_q, state_d;

  always_comb begin
    state_d = {state_q[4:0], state_q[5]};
    if (hold_i) begin
      state_d = state_q;
    end else if (restart_i) begin
      state_d = T1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= T1;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 controller-sequencer: T-state ring plus opcode decode into the control word.
// Define SAP_1_SEQ_SKIP_EN to end short instructions early instead of always using T1-T6.
module sap_1_controller_sequencer
  import sap_1_pkg::*;
(
  input  logic                           Clk,
  input  logic                           Clr,
  sap_1_controller_sequencer_if.master   bus
);

  logic [5:0]     t_q;
  logic           halted_q, halted_d;
  logic           halt_now;
  logic           restart;
  logic [CwW-1:0] cw;

  assign halt_now = (t_q == T4) && (bus.opcode == OP_HLT) && !halted_q;
  assign halted_d = halted_q | halt_now;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

`ifdef SAP_1_SEQ_SKIP_EN
  always_comb begin
    restart = 1'b0;
    if (t_q == T5 && bus.opcode == OP_LDA) begin
      restart = 1'b1;
    end else if (t_q == T4) begin
      // OUT and undefined opcodes have nothing to do after T4
      unique case (bus.opcode)
        OP_LDA, OP_ADD, OP_SUB, OP_HLT: restart = 1'b0;
        default:                        restart = 1'b1;
      endcase
    end
  end
`else
  assign restart = 1'b0;
`endif

  sap_1_ring_counter u_ring (
    .Clk       (Clk),
    .Clr       (Clr),
    .hold_i    (halted_d),
    .restart_i (restart),
    .state_o   (t_q)
  );

  always_comb begin
    cw = '0;
    if (!Clr && !halted_q) begin
      case (t_q)
        T1: begin
          cw[CwEp] = 1'b1;
          cw[CwLm] = 1'b1;
        end
        T2: cw[CwCp] = 1'b1;
        T3: begin
          cw[CwCe] = 1'b1;
          cw[CwLi] = 1'b1;
        end
        T4: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              cw[CwEi] = 1'b1;
              cw[CwLm] = 1'b1;
            end
            OP_OUT: begin
              cw[CwEa] = 1'b1;
              cw[CwLo] = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (bus.opcode)
            OP_LDA: begin
              cw[CwCe] = 1'b1;
              cw[CwLa] = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              cw[CwCe] = 1'b1;
              cw[CwLb] = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            cw[CwLa] = 1'b1;
            cw[CwEu] = 1'b1;
            cw[CwSu] = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.t_state = t_q;
  assign bus.CP  = cw[CwCp];
  assign bus.EP  = cw[CwEp];
  assign bus.LM  = cw[CwLm];
  assign bus.CE  = cw[CwCe];
  assign bus.LI  = cw[CwLi];
  assign bus.EI  = cw[CwEi];
  assign bus.LA  = cw[CwLa];
  assign bus.EA  = cw[CwEa];
  assign bus.SU  = cw[CwSu];
  assign bus.EU  = cw[CwEu];
  assign bus.LB  = cw[CwLb];
  assign bus.LO  = cw[CwLo];
  assign bus.HLT = !Clr && halted_d;

endmodule
